// File: rtl/quad_step_decoder.sv
// Quadrature (x4) decoder: synchronises a/b, emits a step pulse, direction and a wrapping count.
// Optional index input that zeroes the count is enabled with `define QDEC_INDEX_EN.
module quad_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef QDEC_INDEX_EN
    input  logic             idx,
`endif
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             step,
    output logic             up_downbar,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    // Priming must cover the whole synchroniser refill, so that pins held
    // through reset are not mistaken for a two-bit jump.
    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [2:0]             fill_cnt;
    logic [2:0]             fill_cnt_n;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic                   mv_up;
    logic                   mv_dn;
    logic                   mv_bad;
    logic                   idx_rise;
    logic                   step_n;
    logic                   dir_n;
    logic                   err_n;
    logic [WIDTH-1:0]       count_n;

    // Bring the asynchronous phase inputs into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b};
        end
    end

    assign cur = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QDEC_INDEX_EN
    logic [SYNC_STAGES-1:0] sync_i;
    logic                   idx_q;

    // Synchronise the index pin and remember its last value for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_i <= '0;
            idx_q  <= 1'b0;
        end else begin
            sync_i <= {sync_i[SYNC_STAGES-2:0], idx};
            idx_q  <= sync_i[SYNC_STAGES-1];
        end
    end

    assign idx_rise = sync_i[SYNC_STAGES-1] & ~idx_q;
`else
    assign idx_rise = 1'b0;
`endif

    // Classify the {prev,cur} pair as up, down, illegal or idle.
    always_comb begin
        mv_up  = 1'b0;
        mv_dn  = 1'b0;
        mv_bad = 1'b0;
        case ({prev, cur})
            4'b00_10, 4'b10_11,
            4'b11_01, 4'b01_00: mv_up  = 1'b1;
            4'b00_01, 4'b01_11,
            4'b11_10, 4'b10_00: mv_dn  = 1'b1;
            4'b00_11, 4'b11_00,
            4'b01_10, 4'b10_01: mv_bad = 1'b1;
            default: ;
        endcase
    end

    // Next-state: priming sequence, decode, then index load and clr overrides.
    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        step_n     = 1'b0;
        dir_n      = up_downbar;
        count_n    = count;
        err_n      = err;
        unique case (state)
            ST_FILL: begin
                fill_cnt_n = fill_cnt + 3'd1;
                if (fill_cnt == 3'(SYNC_STAGES)) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mv_up) begin
                    step_n  = 1'b1;
                    dir_n   = 1'b1;
                    count_n = count + WIDTH'(1);
                end else if (mv_dn) begin
                    step_n  = 1'b1;
                    dir_n   = 1'b0;
                    count_n = count - WIDTH'(1);
                end else if (mv_bad) begin
                    err_n = 1'b1;
                end
            end
            default: state_n = ST_FILL;
        endcase
        if (idx_rise) begin
            count_n = '0;
        end
        if (clr) begin
            count_n = '0;
            err_n   = 1'b0;
        end
    end

    // Register decoder state and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_FILL;
            fill_cnt   <= 3'd0;
            prev       <= 2'b00;
            step       <= 1'b0;
            up_downbar <= 1'b1;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            fill_cnt   <= fill_cnt_n;
            prev       <= cur;
            step       <= step_n;
            up_downbar <= dir_n;
            count      <= count_n;
            err        <= err_n;
        end
    end

endmodule
